// File: rtl/keypad_4x4_scan_32b.sv
// 4x4 matrix keypad scanner with sweep-level debounce; each accepted hex key is
// shifted into x as the new least-significant digit.
module keypad_4x4_scan_32b #(
  parameter int SCAN_TICKS = 100000,
  parameter int DEBOUNCE   = 20
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        e,
  input  logic [3:0]  ROW,
  output logic [3:0]  COL,
  output logic [31:0] x,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [TW-1:0] TLAST = TW'(SCAN_TICKS - 1);
  localparam logic [SW-1:0] SMAX  = SW'(DEBOUNCE);

  typedef enum logic {ARMED, HELD} state_t;

  logic [3:0]    row_s1, row_s2;
  logic [1:0]    c;
  logic [TW-1:0] tick;
  logic [15:0]   snap, prev;
  logic [SW-1:0] scnt;
  state_t        state;

  logic          col_end;
  logic [15:0]   snap_nx;
  logic [SW-1:0] scnt_nx;
  logic [4:0]    nkeys;
  logic [3:0]    code_nx;

  // Snapshot bit 4c+r holds key (column c, row r).
  function automatic logic [3:0] keymap(input logic [3:0] idx);
    case (idx)
      4'd0:  keymap = 4'h1;  4'd1:  keymap = 4'h4;  4'd2:  keymap = 4'h7;  4'd3:  keymap = 4'h0;
      4'd4:  keymap = 4'h2;  4'd5:  keymap = 4'h5;  4'd6:  keymap = 4'h8;  4'd7:  keymap = 4'hF;
      4'd8:  keymap = 4'h3;  4'd9:  keymap = 4'h6;  4'd10: keymap = 4'h9;  4'd11: keymap = 4'hE;
      4'd12: keymap = 4'hA;  4'd13: keymap = 4'hB;  4'd14: keymap = 4'hC;  default: keymap = 4'hD;
    endcase
  endfunction

  always_comb begin
    col_end = (tick == TLAST);
    snap_nx = snap;
    snap_nx[{c, 2'b00} +: 4] = ~row_s2;
    if (snap_nx == prev) scnt_nx = (scnt == SMAX) ? SMAX : scnt + 1'b1;
    else                 scnt_nx = SW'(1);
    nkeys   = 5'd0;
    code_nx = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (snap_nx[i]) begin
        nkeys   = nkeys + 1'b1;
        code_nx = keymap(4'(i));
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      row_s1    <= 4'hF;
      row_s2    <= 4'hF;
      COL       <= 4'hF;
      c         <= 2'd0;
      tick      <= '0;
      snap      <= 16'h0000;
      prev      <= 16'h0000;
      scnt      <= '0;
      state     <= ARMED;
      x         <= 32'h0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      row_s1    <= ROW;
      row_s2    <= row_s1;
      key_valid <= 1'b0;
      if (!e) begin
        COL   <= 4'hF;
        c     <= 2'd0;
        tick  <= '0;
        scnt  <= '0;
        state <= ARMED;
      end else if (col_end) begin
        tick <= '0;
        c    <= c + 2'd1;
        COL  <= ~(4'b0001 << (c + 2'd1));
        snap <= snap_nx;
        // Sweep end: debounce on whole-keypad snapshots, then step the FSM.
        if (c == 2'd3) begin
          scnt <= scnt_nx;
          prev <= snap_nx;
          if (scnt_nx == SMAX) begin
            case (state)
              ARMED: begin
                if (nkeys == 5'd1) begin
                  key_valid <= 1'b1;
                  key_code  <= code_nx;
                  x         <= {x[27:0], code_nx};
                  state     <= HELD;
                end else if (nkeys >= 5'd2) begin
                  state <= HELD;
                end
              end
              HELD: if (nkeys == 5'd0) state <= ARMED;
              default: state <= ARMED;
            endcase
          end
        end
      end else begin
        tick <= tick + 1'b1;
        COL  <= ~(4'b0001 << c);
      end
    end
  end

endmodule

// File: tb/tb_keypad_4x4_scan_32b.sv
// Keypad scanner bench: a switch-matrix model drives ROW from COL, and a
// sweep-level reference model predicts accepted keys and x.
module tb_keypad_4x4_scan_32b;
  localparam int ST = 4;
  localparam int DB = 3;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        e;
  logic [3:0]  ROW;
  logic [3:0]  COL;
  logic [31:0] x;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] pressed = 16'h0;

  int checks = 0;
  int errors = 0;

  keypad_4x4_scan_32b #(.SCAN_TICKS(ST), .DEBOUNCE(DB)) dut (
    .CLK(CLK), .RST_N(RST_N), .e(e), .ROW(ROW), .COL(COL),
    .x(x), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 CLK = ~CLK;

  // Matrix: row r pulled low when any driven column has key (c,r) pressed.
  always_comb begin
    ROW = 4'hF;
    for (int cc = 0; cc < 4; cc++)
      for (int rr = 0; rr < 4; rr++)
        if (!COL[cc] && pressed[cc*4+rr]) ROW[rr] = 1'b0;
  end

  int         npulse = 0;
  logic [3:0] last_code = 4'h0;
  always @(negedge CLK) begin
    if (key_valid === 1'b1) begin
      npulse++;
      last_code = key_code;
    end
  end

  // Keypad legend, indexed [column][row].
  int kmap [4][4] = '{'{1, 4, 7, 0}, '{2, 5, 8, 15}, '{3, 6, 9, 14}, '{10, 11, 12, 13}};

  function automatic logic [15:0] kmask(input int code);
    logic [15:0] m;
    m = 16'h0;
    for (int cc = 0; cc < 4; cc++)
      for (int rr = 0; rr < 4; rr++)
        if (kmap[cc][rr] == code) m[cc*4+rr] = 1'b1;
    return m;
  endfunction

  logic [15:0] m_prev;
  int          m_run;
  bit          m_armed;
  logic [31:0] m_x;
  logic [3:0]  m_code;
  int          m_pulses = 0;

  task automatic model_reset();
    m_prev = 16'h0; m_run = 0; m_armed = 1'b1; m_x = 32'h0; m_code = 4'h0;
  endtask

  // One full sweep seeing mask m.
  task automatic model_sweep(input logic [15:0] m);
    int n;
    m_run  = (m == m_prev) ? ((m_run < DB) ? m_run + 1 : DB) : 1;
    m_prev = m;
    n = $countones(m);
    if (m_run == DB) begin
      if (m_armed && n == 1) begin
        for (int i = 0; i < 16; i++)
          if (m[i]) m_code = 4'(kmap[i/4][i%4]);
        m_x = (m_x << 4) | {28'h0, m_code};
        m_pulses++;
        m_armed = 1'b0;
      end else if (m_armed && n >= 2) begin
        m_armed = 1'b0;
      end else if (!m_armed && n == 0) begin
        m_armed = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_col(input bit want_c0);
    int w;
    w = 0;
    while (((COL === 4'b1110) != want_c0) && w < 64) begin
      @(negedge CLK);
      w++;
    end
    if (w >= 64) chk("sweep_wait_timeout", 32'(w), 32'd0);
  endtask

  // Apply mask m for n whole sweeps (mask changes at column 0 start), then
  // step into the next sweep so the last sweep's pulse has been seen.
  task automatic do_sweeps(input logic [15:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      wait_col(1'b1);
      pressed = m;
      model_sweep(m);
      wait_col(1'b0);
    end
    wait_col(1'b1);
    @(negedge CLK);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_pulses"}, 32'(npulse), 32'(m_pulses));
    chk({tag, "_x"}, x, m_x);
    chk({tag, "_code"}, {28'h0, key_code}, {28'h0, m_code});
  endtask

  logic [3:0]  colexp;
  logic [31:0] xsave;
  int          psave;

  initial begin
    RST_N = 1'b0; e = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("rst_col", {28'h0, COL}, 32'h0000000F);
    chk("rst_x", x, 32'h0);
    chk("rst_valid", {31'h0, key_valid}, 32'h0);
    chk("rst_code", {28'h0, key_code}, 32'h0);

    // 1. column walk
    e = 1'b1;
    RST_N = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      colexp = ~(4'b0001 << ((i / 4) % 4));
      chk("col_walk", {28'h0, COL}, {28'h0, colexp});
    end
    model_sweep(16'h0);

    // 2. hold '5'
    do_sweeps(kmask(5), DB);
    check_state("hold5");
    chk("hold5_xconst", x, 32'h00000005);
    do_sweeps(kmask(5), 10);
    chk("hold5_norepeat", 32'(npulse), 32'd1);
    do_sweeps(16'h0, DB);

    // 3. digit entry
    for (int d = 1; d <= 8; d++) begin
      do_sweeps(kmask(d), DB);
      do_sweeps(16'h0, DB);
    end
    chk("entry_x8", x, 32'h12345678);
    do_sweeps(kmask(9), DB);
    do_sweeps(16'h0, DB);
    chk("entry_x9", x, 32'h23456789);
    check_state("entry");

    // 4. bounce on '0'
    psave = npulse;
    for (int b = 0; b < 4; b++) do_sweeps((b % 2 == 0) ? kmask(0) : 16'h0, 1);
    do_sweeps(kmask(0), DB + 2);
    chk("bounce_one", 32'(npulse - psave), 32'd1);
    chk("bounce_code", {28'h0, key_code}, 32'h0);
    do_sweeps(16'h0, DB);

    // 5. multi-key then partial release
    psave = npulse; xsave = x;
    do_sweeps(kmask(10) | kmask(3), DB + 1);
    do_sweeps(kmask(10), DB + 2);
    chk("multi_nopulse", 32'(npulse - psave), 32'd0);
    chk("multi_x", x, xsave);
    do_sweeps(16'h0, DB);
    do_sweeps(kmask(10), DB);
    chk("multi_A", {28'h0, last_code}, 32'hA);
    check_state("multi");
    do_sweeps(16'h0, DB);

    // 6a. drop e while debouncing '7'
    psave = npulse; xsave = x;
    do_sweeps(kmask(7), DB - 1);
    e = 1'b0;
    repeat (6) @(negedge CLK);
    chk("edrop_col", {28'h0, COL}, 32'h0000000F);
    pressed = 16'h0;
    m_run = 0; m_armed = 1'b1;
    e = 1'b1;
    do_sweeps(16'h0, DB);
    chk("edrop_nopulse", 32'(npulse - psave), 32'd0);
    chk("edrop_x", x, xsave);

    // 6b. reset while debouncing '7'
    do_sweeps(kmask(7), DB - 1);
    RST_N = 1'b0;
    #1;
    chk("rstmid_x", x, 32'h0);
    chk("rstmid_col", {28'h0, COL}, 32'h0000000F);
    @(negedge CLK);
    pressed = 16'h0;
    model_reset();
    RST_N = 1'b1;
    do_sweeps(16'h0, DB);
    chk("rstmid_nopulse", 32'(npulse - psave), 32'd0);
    check_state("rstmid");

    // randomized press patterns
    for (int it = 0; it < 10; it++) begin
      int kind, k1, k2;
      kind = int'($urandom_range(0, 3));
      k1 = int'($urandom_range(0, 15));
      k2 = int'($urandom_range(0, 15));
      case (kind)
        0: begin
          do_sweeps(kmask(k1), DB + int'($urandom_range(0, 2)));
          do_sweeps(16'h0, DB + int'($urandom_range(0, 1)));
        end
        1: begin
          for (int b = 0; b < int'($urandom_range(1, 4)); b++)
            do_sweeps(kmask(k1), int'($urandom_range(1, DB - 1)));
          do_sweeps(kmask(k1), DB);
        end
        2: begin
          do_sweeps(kmask(k1) | kmask(k2), DB);
          do_sweeps(kmask(k1), int'($urandom_range(1, DB + 1)));
        end
        default: begin
          do_sweeps(16'($urandom), int'($urandom_range(1, DB + 1)));
          do_sweeps(16'h0, int'($urandom_range(1, DB + 1)));
        end
      endcase
      check_state("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
